// File: rtl/key_fifo_pkg.sv
// Shared definitions for the key event FIFO: key width, default sizing and
// the downstream handshake FSM state encoding.
package key_fifo_pkg;

   localparam int KEY_W            = 4;
   localparam int DEF_DEPTH        = 8;
   localparam int DEF_BUSY_TIMEOUT = 16;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_STROBE    = 2'd1,
      ST_WAIT_BUSY = 2'd2,
      ST_WAIT_IDLE = 2'd3
   } state_t;

endpackage

// File: rtl/key_event_fifo_if.sv
// Key FIFO signal bundle. The slave side is the FIFO itself; the master side
// is the surrounding keypad / LCD environment.
interface key_event_fifo_if
   import key_fifo_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH
);

   localparam int LVL_W = $clog2(DEPTH) + 1;

   logic [KEY_W-1:0] i_data;
   logic             i_cs;
   logic             i_busy;
   logic             i_clr_ovf;
   logic [KEY_W-1:0] o_data;
   logic             o_cs;
   logic [LVL_W-1:0] o_level;
   logic             o_empty;
   logic             o_full;
   logic             o_overflow;

   modport slave (
      input  i_data, i_cs, i_busy, i_clr_ovf,
      output o_data, o_cs, o_level, o_empty, o_full, o_overflow
   );

   modport master (
      output i_data, i_cs, i_busy, i_clr_ovf,
      input  o_data, o_cs, o_level, o_empty, o_full, o_overflow
   );

endinterface

// File: rtl/key_fifo_mem.sv
// DEPTH x KEY_W storage array: synchronous write, combinational read.
// The array carries no reset; validity is tracked by the pointers/level.
module key_fifo_mem
   import key_fifo_pkg::*;
#(
   parameter int DEPTH  = DEF_DEPTH,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              i_clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [KEY_W-1:0]  wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [KEY_W-1:0]  rd_data
);

   logic [KEY_W-1:0] mem [DEPTH];

   // Write the incoming key at the write pointer.
   always_ff @(posedge i_clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Head of queue is always visible so a pop can capture it at its edge.
   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/key_event_fifo.sv
// Queues keypad key codes and hands them to the LCD controller one at a time.
// A key is released only when the FIFO is non-empty and the LCD path is idle;
// the next one waits until the LCD has gone busy and back to idle, or until
// the busy-rise timeout expires (key treated as consumed).
module key_event_fifo
   import key_fifo_pkg::*;
#(
   parameter int DEPTH        = DEF_DEPTH,
   parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
   input  logic            i_clk,
   input  logic            i_reset,
   key_event_fifo_if.slave bus
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int TMO_W = $clog2(BUSY_TIMEOUT + 1);

   localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BUSY_TIMEOUT - 1);

   state_t           state_q;
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [LVL_W-1:0] level_q;
   logic             empty_q;
   logic             full_q;
   logic             ovf_q;
   logic [TMO_W-1:0] tmo_q;
   logic [KEY_W-1:0] data_q;
   logic             cs_q;

   logic [KEY_W-1:0] rd_data;
   logic             pop;
   logic             push;
   logic             drop;
   logic [LVL_W-1:0] level_nxt;

   key_fifo_mem #(
      .DEPTH  (DEPTH),
      .ADDR_W (PTR_W)
   ) u_mem (
      .i_clk   (i_clk),
      .wr_en   (push),
      .wr_addr (wr_ptr_q),
      .wr_data (bus.i_data),
      .rd_addr (rd_ptr_q),
      .rd_data (rd_data)
   );

   // Pop/push decisions; a pop at the same edge frees the slot a full-FIFO push needs.
   always_comb begin
      pop       = (state_q == ST_IDLE) && !empty_q && !bus.i_busy;
      push      = bus.i_cs && (!full_q || pop);
      drop      = bus.i_cs && !push;
      level_nxt = level_q;
      if (push && !pop) begin
         level_nxt = level_q + LVL_W'(1);
      end else if (pop && !push) begin
         level_nxt = level_q - LVL_W'(1);
      end
   end

   // Pointers, occupancy, registered status flags and the sticky overflow.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         level_q <= level_nxt;
         empty_q <= (level_nxt == '0);
         full_q  <= (level_nxt == FULL_LVL);
         // A drop at the same edge as a clear must leave the flag set.
         if (drop) begin
            ovf_q <= 1'b1;
         end else if (bus.i_clr_ovf) begin
            ovf_q <= 1'b0;
         end
      end
   end

   // Downstream handshake FSM with registered strobe and data outputs.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         state_q <= ST_IDLE;
         tmo_q   <= '0;
         data_q  <= '0;
         cs_q    <= 1'b0;
      end else begin
         cs_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (pop) begin
                  state_q <= ST_STROBE;
                  data_q  <= rd_data;
                  cs_q    <= 1'b1;
               end
            end
            ST_STROBE: begin
               // Busy is deliberately not looked at here.
               state_q <= ST_WAIT_BUSY;
               tmo_q   <= '0;
            end
            ST_WAIT_BUSY: begin
               if (bus.i_busy) begin
                  state_q <= ST_WAIT_IDLE;
               end else if (tmo_q == TMO_LAST) begin
                  state_q <= ST_IDLE;
               end else begin
                  tmo_q <= tmo_q + TMO_W'(1);
               end
            end
            ST_WAIT_IDLE: begin
               if (!bus.i_busy) begin
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.o_data     = data_q;
   assign bus.o_cs       = cs_q;
   assign bus.o_level    = level_q;
   assign bus.o_empty    = empty_q;
   assign bus.o_full     = full_q;
   assign bus.o_overflow = ovf_q;

endmodule

// File: tb/tb_key_event_fifo.sv
// Bench for key_event_fifo: a vector table for single-key flow and handshake,
// followed by hand-written multi-cycle sequences.
module tb_key_event_fifo;
   import key_fifo_pkg::*;

   localparam int DEPTH = 8;
   localparam int TMO   = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   tests = 0;
   int   fails = 0;

   key_event_fifo_if #(.DEPTH(DEPTH)) bus ();

   key_event_fifo #(
      .DEPTH        (DEPTH),
      .BUSY_TIMEOUT (TMO)
   ) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst_n;
      logic       cs;
      logic [3:0] data;
      logic       busy;
      logic       clr;
      logic       exp_cs;
      logic [3:0] exp_data;
      logic [3:0] exp_level;
      logic       exp_empty;
      logic       exp_full;
      logic       exp_ovf;
   } vec_t;

   vec_t vecs [10];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Ticks until o_cs is seen; n is the tick count, or -1 if the bound expired.
   task automatic wait_cs(input int max, output int n, output logic [3:0] d);
      n = -1;
      d = '0;
      for (int i = 1; i <= max; i++) begin
         tick();
         if (bus.o_cs === 1'b1) begin
            n = i;
            d = bus.o_data;
            break;
         end
      end
   endtask

   task automatic do_reset();
      bus.i_cs      = 1'b0;
      bus.i_data    = '0;
      bus.i_busy    = 1'b0;
      bus.i_clr_ovf = 1'b0;
      rst = 1'b0;
      tick();
      rst = 1'b1;
   endtask

   task automatic push(input logic [3:0] k);
      bus.i_cs   = 1'b1;
      bus.i_data = k;
      tick();
      bus.i_cs   = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int         n;
      logic [3:0] d;
      logic [3:0] exp_k [3];

      bus.i_cs      = 1'b0;
      bus.i_data    = '0;
      bus.i_busy    = 1'b0;
      bus.i_clr_ovf = 1'b0;

      //          rst cs data  busy clr | cs data  lvl emp full ovf
      vecs[0] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'd0, 1'b1, 1'b0, 1'b0};
      vecs[1] = '{1'b1, 1'b1, 4'hA, 1'b0, 1'b0, 1'b0, 4'h0, 4'd1, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'hA, 4'd0, 1'b1, 1'b0, 1'b0};
      vecs[3] = '{1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'hA, 4'd0, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{1'b1, 1'b1, 4'h3, 1'b1, 1'b0, 1'b0, 4'hA, 4'd1, 1'b0, 1'b0, 1'b0};
      vecs[5] = '{1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'hA, 4'd1, 1'b0, 1'b0, 1'b0};
      vecs[6] = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'hA, 4'd1, 1'b0, 1'b0, 1'b0};
      vecs[7] = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'h3, 4'd0, 1'b1, 1'b0, 1'b0};
      vecs[8] = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h3, 4'd0, 1'b1, 1'b0, 1'b0};
      vecs[9] = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h3, 4'd0, 1'b1, 1'b0, 1'b0};

      tick();
      for (int i = 0; i < 10; i++) begin
         rst           = vecs[i].rst_n;
         bus.i_cs      = vecs[i].cs;
         bus.i_data    = vecs[i].data;
         bus.i_busy    = vecs[i].busy;
         bus.i_clr_ovf = vecs[i].clr;
         tick();
         tests++;
         if (bus.o_cs !== vecs[i].exp_cs || bus.o_data !== vecs[i].exp_data ||
             bus.o_level !== vecs[i].exp_level || bus.o_empty !== vecs[i].exp_empty ||
             bus.o_full !== vecs[i].exp_full || bus.o_overflow !== vecs[i].exp_ovf) begin
            fails++;
            $display("FAIL vec%0d: got cs=%b data=%h lvl=%0d emp=%b full=%b ovf=%b, expected cs=%b data=%h lvl=%0d emp=%b full=%b ovf=%b",
                     i, bus.o_cs, bus.o_data, bus.o_level, bus.o_empty, bus.o_full, bus.o_overflow,
                     vecs[i].exp_cs, vecs[i].exp_data, vecs[i].exp_level, vecs[i].exp_empty,
                     vecs[i].exp_full, vecs[i].exp_ovf);
         end
      end
      bus.i_clr_ovf = 1'b0;

      // Busy backlog: keys held while busy, then released one per busy pulse.
      do_reset();
      bus.i_busy = 1'b1;
      push(4'h3); chk("backlog_no_cs0", bus.o_cs, 0);
      push(4'h5); chk("backlog_no_cs1", bus.o_cs, 0);
      push(4'h7); chk("backlog_no_cs2", bus.o_cs, 0);
      tick();     chk("backlog_no_cs3", bus.o_cs, 0);
      chk("backlog_level", bus.o_level, 3);
      exp_k[0] = 4'h3; exp_k[1] = 4'h5; exp_k[2] = 4'h7;
      for (int k = 0; k < 3; k++) begin
         bus.i_busy = 1'b0;
         wait_cs(10, n, d);
         chk($sformatf("backlog_gap%0d", k), n, (k == 0) ? 1 : 2);
         chk($sformatf("backlog_key%0d", k), d, exp_k[k]);
         bus.i_busy = 1'b1;
         for (int j = 0; j < 3; j++) begin
            tick();
            chk($sformatf("backlog_hold%0d_%0d", k, j), bus.o_cs, 0);
         end
      end
      bus.i_busy = 1'b0;
      wait_cs(10, n, d);
      chk("backlog_no_extra", n, 32'hFFFF_FFFF);
      chk("backlog_empty", bus.o_empty, 1);

      // Overflow: ninth key dropped, clear, clear-vs-drop priority, drain.
      do_reset();
      bus.i_busy = 1'b1;
      for (int k = 1; k <= 8; k++) push(4'(k));
      chk("ovf_full", bus.o_full, 1);
      chk("ovf_level8", bus.o_level, 8);
      chk("ovf_pre", bus.o_overflow, 0);
      push(4'h9);
      chk("ovf_set", bus.o_overflow, 1);
      chk("ovf_level_kept", bus.o_level, 8);
      bus.i_clr_ovf = 1'b1; tick(); bus.i_clr_ovf = 1'b0;
      chk("ovf_clr", bus.o_overflow, 0);
      bus.i_clr_ovf = 1'b1; push(4'hE); bus.i_clr_ovf = 1'b0;
      chk("ovf_set_wins", bus.o_overflow, 1);
      bus.i_clr_ovf = 1'b1; tick(); bus.i_clr_ovf = 1'b0;
      chk("ovf_clr2", bus.o_overflow, 0);
      bus.i_busy = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         wait_cs(20, n, d);
         chk($sformatf("ovf_seen%0d", k), (n > 0) ? 1 : 0, 1);
         chk($sformatf("ovf_key%0d", k), d, k);
      end
      wait_cs(20, n, d);
      chk("ovf_no_ninth", n, 32'hFFFF_FFFF);
      chk("ovf_drained", bus.o_level, 0);

      // Push into a full FIFO at the pop edge is accepted.
      do_reset();
      bus.i_busy = 1'b1;
      for (int k = 0; k < 8; k++) push(4'(8 + k));
      chk("fpop_level_pre", bus.o_level, 8);
      bus.i_busy = 1'b0;
      push(4'h0);
      chk("fpop_cs", bus.o_cs, 1);
      chk("fpop_data", bus.o_data, 4'h8);
      chk("fpop_level", bus.o_level, 8);
      chk("fpop_full", bus.o_full, 1);
      chk("fpop_no_ovf", bus.o_overflow, 0);
      for (int k = 1; k <= 8; k++) begin
         wait_cs(20, n, d);
         chk($sformatf("fpop_key%0d", k), d, (8 + k) % 16);
      end
      chk("fpop_drained", bus.o_empty, 1);

      // Timeout path: busy never rises, strobes 1+TMO+1 cycles apart.
      do_reset();
      push(4'h6);
      push(4'hC);
      chk("tmo_cs1", bus.o_cs, 1);
      chk("tmo_key1", bus.o_data, 4'h6);
      chk("tmo_level", bus.o_level, 1);
      wait_cs(20, n, d);
      chk("tmo_spacing", n, 1 + TMO + 1);
      chk("tmo_key2", d, 4'hC);
      wait_cs(20, n, d);
      chk("tmo_no_extra", n, 32'hFFFF_FFFF);

      // Reset while waiting for idle with three keys queued.
      do_reset();
      push(4'h1);
      bus.i_cs = 1'b1; bus.i_data = 4'h2; tick();
      chk("mrst_cs", bus.o_cs, 1);
      chk("mrst_key", bus.o_data, 4'h1);
      bus.i_busy = 1'b1;
      bus.i_data = 4'h3; tick();
      bus.i_data = 4'h4; tick();
      bus.i_cs = 1'b0;
      chk("mrst_level3", bus.o_level, 3);
      rst = 1'b0; tick(); rst = 1'b1;
      chk("mrst_level0", bus.o_level, 0);
      chk("mrst_cs_low", bus.o_cs, 0);
      chk("mrst_empty", bus.o_empty, 1);
      chk("mrst_data0", bus.o_data, 0);
      bus.i_busy = 1'b0;
      wait_cs(20, n, d);
      chk("mrst_no_strobe", n, 32'hFFFF_FFFF);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
